// File: rtl/dcache_refill.sv
// Miss-handling sequencer for the 4-way data cache: optional dirty-victim writeback, then line fill.
// Define DCACHE_CWF_EN for critical-word-first fill plus the early_valid/early_data ports.
//
// state | meaning
// IDLE  | waiting for miss_req
// WB    | writing dirty victim line to memory, word 0 upward
// FILL  | reading new line from memory into the chosen way
// DONE  | one-cycle completion pulse
module dcache_refill #(
  parameter int DW = 32,
  parameter int IW = 5,
  parameter int OW = 3,
  parameter int TW = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_req,
  input  logic [TW-1:0]       miss_tag,
  input  logic [IW-1:0]       miss_index,
  input  logic [OW-1:0]       miss_offset,
  input  logic [1:0]          miss_way,
  input  logic                victim_dirty,
  input  logic [TW-1:0]       victim_tag,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [TW+IW+OW-1:0] mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic                mem_ack,
  input  logic [DW-1:0]       mem_rdata,
  output logic [IW-1:0]       ram_index,
  output logic [1:0]          ram_way,
  output logic [OW-1:0]       ram_offset,
  output logic [DW-1:0]       ram_din,
  output logic                ram_we,
  output logic                ram_en,
  input  logic [DW-1:0]       ram_dout0,
  input  logic [DW-1:0]       ram_dout1,
  input  logic [DW-1:0]       ram_dout2,
  input  logic [DW-1:0]       ram_dout3
`ifdef DCACHE_CWF_EN
  ,
  output logic                early_valid,
  output logic [DW-1:0]       early_data
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

  state_t        state, state_nx;
  logic [OW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tag_q, vtag_q;
  logic [IW-1:0] index_q;
  logic [1:0]    way_q;
  logic [OW-1:0] word;
  logic [DW-1:0] victim_data;
  logic          last;

`ifdef DCACHE_CWF_EN
  logic [OW-1:0] offset_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
    end else if (state == S_IDLE && miss_req) begin
      offset_q <= miss_offset;
    end
  end

  // Fill wraps around the line starting at the requested word.
  assign word        = offset_q + cnt;
  assign early_valid = (state == S_FILL) && (cnt == '0) && mem_ack;
  assign early_data  = early_valid ? mem_rdata : '0;
`else
  logic unused_offset;
  assign unused_offset = ^miss_offset;
  assign word          = cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      index_q <= '0;
      way_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && miss_req) begin
        tag_q   <= miss_tag;
        vtag_q  <= victim_tag;
        index_q <= miss_index;
        way_q   <= miss_way;
      end
    end
  end

  always_comb begin
    case (way_q)
      2'd0:    victim_data = ram_dout0;
      2'd1:    victim_data = ram_dout1;
      2'd2:    victim_data = ram_dout2;
      default: victim_data = ram_dout3;
    endcase
  end

  assign last = (cnt == {OW{1'b1}});

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ram_index  = '0;
    ram_way    = '0;
    ram_offset = '0;
    ram_din    = '0;
    ram_we     = 1'b0;
    ram_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (miss_req) begin
          cnt_nx   = '0;
          state_nx = victim_dirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        busy       = 1'b1;
        ram_en     = 1'b1;
        ram_index  = index_q;
        ram_way    = way_q;
        ram_offset = cnt;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {vtag_q, index_q, cnt};
        mem_wdata  = victim_data;
        if (mem_ack) begin
          cnt_nx = cnt + OW'(1);
          if (last) state_nx = S_FILL;
        end
      end
      S_FILL: begin
        busy       = 1'b1;
        ram_en     = 1'b1;
        ram_index  = index_q;
        ram_way    = way_q;
        ram_offset = word;
        ram_din    = mem_rdata;
        ram_we     = mem_ack;
        mem_req    = 1'b1;
        mem_addr   = {tag_q, index_q, word};
        if (mem_ack) begin
          cnt_nx = cnt + OW'(1);
          if (last) state_nx = S_DONE;
        end
      end
      default: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_refill.sv
// Self-checking bench for dcache_refill: table of miss scenarios plus reset/spurious-ack sequences.
// Memory and RAM read data come from simple models; expected transfers are queued per miss.
module tb_dcache_refill;
  localparam int DW = 32, IW = 5, OW = 3, TW = 22, AW = TW + IW + OW, NW = 8;

  logic clk, rst_n;
  logic miss_req, victim_dirty;
  logic [TW-1:0] miss_tag, victim_tag;
  logic [IW-1:0] miss_index;
  logic [OW-1:0] miss_offset;
  logic [1:0] miss_way;
  logic busy, done, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [IW-1:0] ram_index;
  logic [1:0] ram_way;
  logic [OW-1:0] ram_offset;
  logic [DW-1:0] ram_din, ram_dout0, ram_dout1, ram_dout2, ram_dout3;
  logic ram_we, ram_en;
`ifdef DCACHE_CWF_EN
  logic early_valid;
  logic [DW-1:0] early_data;
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  dcache_refill #(.DW(DW), .IW(IW), .OW(OW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_tag(miss_tag),
    .miss_index(miss_index), .miss_offset(miss_offset), .miss_way(miss_way),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ram_index(ram_index), .ram_way(ram_way),
    .ram_offset(ram_offset), .ram_din(ram_din), .ram_we(ram_we), .ram_en(ram_en),
    .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2), .ram_dout3(ram_dout3)
`ifdef DCACHE_CWF_EN
    , .early_valid(early_valid), .early_data(early_data)
`endif
  );

  function automatic logic [DW-1:0] dout_model(int w, logic [OW-1:0] off);
    if (w == 1) return 32'hB0 + DW'(off);
    return 32'hE00 + DW'(w * 16) + DW'(off);
  endfunction

  assign ram_dout0 = dout_model(0, ram_offset);
  assign ram_dout1 = dout_model(1, ram_offset);
  assign ram_dout2 = dout_model(2, ram_offset);
  assign ram_dout3 = dout_model(3, ram_offset);
  assign mem_rdata = 32'hA0 + DW'(mem_addr[OW-1:0]);

  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} mem_t;
  typedef struct {logic [1:0] way; logic [IW-1:0] idx; logic [OW-1:0] off; logic [DW-1:0] din;} ramw_t;
  typedef struct {
    logic [TW-1:0] tag; logic [IW-1:0] idx; logic [OW-1:0] off; logic [1:0] way;
    logic dirty; logic [TW-1:0] vtag; int period; logic poke; int lat;
  } vec_t;

  mem_t exp_mem[$];
  ramw_t exp_ram[$];
  logic [DW-1:0] exp_early[$];

  int total = 0, bad = 0;
  int cyc = 0, ph = 0, period = 1;
  int ndone = 0, nram = 0, nmem = 0;
  logic spur = 1'b0;
  logic prev_req = 1'b0, prev_ack = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ack on every period-th cycle of an outstanding request.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (spur) mem_ack = 1'b1;
      else if (mem_req) begin
        ph++;
        mem_ack = ((ph % period) == 0);
      end else mem_ack = 1'b0;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    mem_t m;
    ramw_t r;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_req = 1'b0;
      else begin
        if (prev_req && !prev_ack) begin
          chk("req_hold", mem_req, 1);
          chk("addr_hold", mem_addr, prev_addr);
          chk("wdata_hold", mem_wdata, prev_wdata);
        end
        if (mem_req && mem_ack) begin
          nmem++;
          if (exp_mem.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_mem: got addr %0h expected no transfer", mem_addr);
          end else begin
            m = exp_mem.pop_front();
            chk("mem_we", mem_we, m.we);
            chk("mem_addr", mem_addr, m.addr);
            if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
          end
        end
        if (ram_we) begin
          nram++;
          if (exp_ram.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_ram: got offset %0d expected no write", ram_offset);
          end else begin
            r = exp_ram.pop_front();
            chk("ram_en", ram_en, 1);
            chk("ram_way", ram_way, r.way);
            chk("ram_index", ram_index, r.idx);
            chk("ram_offset", ram_offset, r.off);
            chk("ram_din", ram_din, r.din);
          end
        end
`ifdef DCACHE_CWF_EN
        if (early_valid) begin
          if (exp_early.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_early: got %0h expected no pulse", early_data);
          end else begin
            e = exp_early.pop_front();
            chk("early_data", early_data, e);
          end
        end
`endif
        if (done) ndone++;
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_addr = mem_addr;
        prev_wdata = mem_wdata;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ctl"}, {busy, done, mem_req, mem_we, ram_we, ram_en}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_ram_bus"}, {ram_index, ram_way, ram_offset}, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
  endtask

  // Caller must be at posedge+1; returns at posedge+1 of the cycle after done.
  task automatic run(input vec_t v);
    logic [OW-1:0] w;
    int t0, tdone, d0;
    bit got;
    ph = 0;
    period = v.period;
    if (v.dirty)
      for (int i = 0; i < NW; i++) begin
        w = OW'(i);
        exp_mem.push_back('{1'b1, {v.vtag, v.idx, w}, dout_model(int'(v.way), w)});
      end
    for (int i = 0; i < NW; i++) begin
      w = CWF ? OW'(v.off + OW'(i)) : OW'(i);
      exp_mem.push_back('{1'b0, {v.tag, v.idx, w}, '0});
      exp_ram.push_back('{v.way, v.idx, w, 32'hA0 + DW'(w)});
    end
`ifdef DCACHE_CWF_EN
    exp_early.push_back(32'hA0 + DW'(v.off));
`endif
    chk("busy_before", busy, 0);
    miss_tag = v.tag; miss_index = v.idx; miss_offset = v.off; miss_way = v.way;
    victim_dirty = v.dirty; victim_tag = v.vtag;
    miss_req = 1'b1;
    t0 = cyc; d0 = ndone; tdone = 0; got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge clk); #1;
      if (i == 0) chk("busy_rise", busy, 1);
      miss_req = v.poke && (i == 2);
      if (i == 2) begin
        miss_tag = ~v.tag; miss_way = ~v.way; victim_dirty = ~v.dirty;
      end
      @(negedge clk);
      if (done) begin got = 1; tdone = cyc; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done within 600 cycles");
    end
    chk("latency", tdone - t0 + 1, v.lat);
    @(posedge clk); #1;
    chk("done_once", ndone - d0, 1);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    chk("mem_left", exp_mem.size(), 0);
    chk("ram_left", exp_ram.size(), 0);
    chk("early_left", exp_early.size(), 0);
  endtask

  vec_t vt[5];
  vec_t vr;

  initial begin
    int n0, m0;
    vt[0] = '{22'h1, 5'd3, 3'd0, 2'd2, 1'b0, 22'h0, 1, 1'b0, 10};
    vt[1] = '{22'h2A, 5'd7, 3'd4, 2'd1, 1'b1, 22'h5, 1, 1'b0, 18};
    vt[2] = '{22'h3FFFFF, 5'd31, 3'd7, 2'd3, 1'b0, 22'h0, 3, 1'b1, 26};
    vt[3] = '{22'h123, 5'd0, 3'd5, 2'd0, 1'b1, 22'h2AAAAA, 3, 1'b0, 50};
    vt[4] = '{22'h7, 5'd16, 3'd5, 2'd1, 1'b1, 22'h5, 2, 1'b1, 34};
    vr = '{22'h11, 5'd9, 3'd0, 2'd3, 1'b0, 22'h0, 1, 1'b0, 10};

    rst_n = 1'b0;
    miss_req = 1'b0; miss_tag = '0; miss_index = '0; miss_offset = '0;
    miss_way = '0; victim_dirty = 1'b0; victim_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Runs are back-to-back: each miss_req lands in the cycle after the previous done.
    for (int k = 0; k < 5; k++) run(vt[k]);

    // Spurious acks while idle must cause no activity.
    n0 = nram; m0 = nmem;
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #2 spur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("spur_busy", busy, 0);
    chk("spur_ram", nram - n0, 0);
    chk("spur_mem", nmem - m0, 0);

    // Abort mid-fill after three words, then a fresh miss starts from the beginning.
    ph = 0; period = 1;
    n0 = nram;
    miss_tag = 22'h99; miss_index = 5'd9; miss_offset = 3'd0; miss_way = 2'd3;
    victim_dirty = 1'b0;
    for (int i = 0; i < NW; i++) begin
      exp_mem.push_back('{1'b0, {22'h99, 5'd9, OW'(i)}, '0});
      exp_ram.push_back('{2'd3, 5'd9, OW'(i), 32'hA0 + DW'(i)});
    end
`ifdef DCACHE_CWF_EN
    exp_early.push_back(32'hA0);
`endif
    miss_req = 1'b1;
    @(posedge clk); #1 miss_req = 1'b0;
    for (int i = 0; i < 50 && (nram - n0) < 3; i++) @(negedge clk);
    chk("pre_reset_writes", nram - n0, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    exp_mem.delete(); exp_ram.delete(); exp_early.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run(vr);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_refill.md
Name: dcache_refill

Overview:
- Miss-handling sequencer for the 4-way data cache; sits directly upstream of the data-array RAM and drives its index/way/offset/din/we/en ports.
- On a miss, optionally writes back the dirty victim line word by word, then fetches the new line from memory and writes it into the chosen way.
- Signals completion to the cache controller.

Parameters:
- DW, 32, data word width.
- IW, 5, index width (matches D_INDEX_WIDTH).
- OW, 3, word-offset width; a line is 2**OW words.
- TW, 22, tag width; memory word address = {tag, index, offset}, TW+IW+OW bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- miss_req  in  1  one-cycle miss pulse; sampled only in IDLE.
- miss_tag  in  TW  tag of missing line.
- miss_index  in  IW  set index.
- miss_offset  in  OW  offset of requested word.
- miss_way  in  2  victim way.
- victim_dirty  in  1  victim line needs writeback.
- victim_tag  in  TW  tag of victim line.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the line is fully installed.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write (writeback), 0 = read (fill).
- mem_addr  out  TW+IW+OW  memory word address.
- mem_wdata  out  DW  writeback data.
- mem_ack  in  1  completes the current request; mem_rdata valid the same cycle.
- mem_rdata  in  DW  fill data.
- ram_index  out  IW  to data array.
- ram_way  out  2  to data array.
- ram_offset  out  OW  to data array.
- ram_din  out  DW  to data array.
- ram_we  out  1  to data array.
- ram_en  out  1  to data array.
- ram_dout0..ram_dout3  in  DW each  combinational read data of ways 0..3.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; counters 0; latched tag/index/way/offset 0.
  - busy, done, mem_req, mem_we, ram_we, ram_en all 0.
  - mem_addr, mem_wdata, ram_* buses 0.
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - On miss_req=1, latch tag, index, offset, way, victim_tag.
  - Set cnt=0 and go to WB if victim_dirty=1, otherwise FILL. busy rises the next cycle.
- WB:
  - ram_en=1, ram_index=latched index, ram_offset=cnt, ram_way=way.
  - mem_req=1, mem_we=1, mem_addr={victim_tag, index, cnt}.
  - mem_wdata=ram_dout[way] (combinational mux).
  - On mem_ack: cnt+1. If cnt==2**OW-1, clear cnt and go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={tag, index, word}, where word=cnt (wrap variant below).
  - ram_en=1, ram_offset=word, ram_din=mem_rdata.
  - ram_we=mem_ack, so the RAM captures the word on the falling edge of the same cycle.
  - On mem_ack: cnt+1. After the last word, go to DONE.
- DONE:
  - done=1 for one cycle, busy=1, ram_en=0.
  - Next state IDLE.
- mem_req is never dropped before mem_ack. mem_addr and mem_wdata are stable while mem_req=1 and mem_ack=0.
- Counter width is OW; offset arithmetic is modulo 2**OW.
- miss_req outside IDLE is ignored and not queued.
- Reset mid-transfer aborts immediately. Any RAM words already written remain; the controller must re-issue the miss.
- mem_ack while mem_req=0 is ignored.
- Back-to-back: miss_req in the cycle after done is accepted.
- Latency with zero-wait memory (ack same cycle as req):
  - Clean miss: miss_req to done = 2**OW + 2 cycles.
  - Dirty miss: 2*2**OW + 2 cycles.

Optional Feature:
- Macro: DCACHE_CWF_EN (critical word first).
- Defined:
  - FILL order starts at the latched miss_offset and wraps: word = miss_offset + cnt (mod 2**OW).
  - Adds outputs early_valid (1 bit) and early_data (DW). early_valid pulses for one cycle on the mem_ack of the first fill beat, with early_data = mem_rdata.
  - Writeback order is unchanged (0 upward).
- Undefined:
  - Fill always starts at word 0; early_valid/early_data ports are absent.

Test Plan:
- Clean miss: tag=0x1, index=3, way=2, dirty=0, mem_ack every cycle, rdata = 0xA0+word → 8 RAM writes to way 2, index 3, offsets 0..7, din 0xA0..0xA7; done at cycle 10 after miss_req; busy low after.
- Dirty miss: victim_tag=0x5, way=1, ram_dout1 = 0xB0+offset → 8 mem writes to addr {0x5,index,0..7} with wdata 0xB0..0xB7, then 8 fills; no ram_we during WB.
- Wait states: mem_ack every 3rd cycle → mem_req/mem_addr stay stable across stalls, exactly 8 ram_we pulses, done once.
- Reset mid-FILL: assert rst_n=0 after 3 acks → all outputs 0 immediately; a new miss_req after release runs a full sequence from word 0.
- miss_req during busy plus a spurious mem_ack in IDLE → both ignored; no extra RAM or memory activity.
- DCACHE_CWF_EN, miss_offset=5 → fill order 5,6,7,0..4; early_valid on the first ack with early_data = word-5 data.
